// File: rtl/temp_convert_pipe.sv
// temp_convert_pipe: 3-stage signed F<->C converter, valid/ready on both
// sides, with per-channel last-result readback registers.
module temp_convert_pipe #(
    parameter int W_IN  = 10,
    parameter int W_OUT = 16,
    parameter int FRAC  = 4,
    parameter int NCH   = 4,
    localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [W_IN-1:0]  in_temp,
    input  logic                    in_mode,
    input  logic [CW-1:0]           in_ch,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [W_OUT-1:0] out_temp,
    output logic [CW-1:0]           out_ch,
    output logic                    out_sat,
    input  logic [CW-1:0]           rd_ch,
    output logic signed [W_OUT-1:0] rd_temp,
    output logic                    rd_vld
);

    localparam int N  = W_IN + FRAC + 6;
    localparam int SH = N + 5;
    localparam int SW = SH + 1;
    localparam int RW = SH - 3;
    localparam int PW = N + RW;
    localparam int QW = PW - SH;
    localparam int EW = ((N > W_OUT) ? N : W_OUT) + 1;
    localparam int NS = 1 << CW;

    function automatic logic [NS-1:0] ch_mask();
        logic [NS-1:0] m;
        for (int i = 0; i < NS; i++) m[i] = (i < NCH);
        return m;
    endfunction

    localparam logic [NS-1:0] CH_OK = ch_mask();

    // floor(x/D) == (x*ceil(2^SH/D)) >> SH holds for every x < 2^N, D <= 32
    localparam logic [SW-1:0] P2  = {1'b1, {SH{1'b0}}};
    localparam logic [RW-1:0] R18 = RW'((P2 + SW'(17)) / SW'(18));
    localparam logic [RW-1:0] R10 = RW'((P2 + SW'(9)) / SW'(10));

    localparam logic signed [N-1:0]  KFC  = N'(5 << FRAC);
    localparam logic signed [N-1:0]  KCF  = N'(9 << FRAC);
    localparam logic signed [N-1:0]  F32  = N'(32);
    localparam logic signed [EW-1:0] OFS  = EW'(32 << FRAC);
    localparam logic signed [EW-1:0] MAXV =
        {{(EW-W_OUT+1){1'b0}}, {(W_OUT-1){1'b1}}};
    localparam logic signed [EW-1:0] MINV =
        {{(EW-W_OUT+1){1'b1}}, {(W_OUT-1){1'b0}}};

    logic en1, en2, en3, take, xfer;

    logic              s1_v, s1_neg, s1_mode;
    logic [N-1:0]      s1_x;
    logic [CW-1:0]     s1_ch;
    logic              s2_v, s2_neg, s2_mode;
    logic [QW-1:0]     s2_q;
    logic [CW-1:0]     s2_ch;

    logic signed [N-1:0]      ext, n_val;
    logic [N-1:0]             mag, x_val;
    logic [PW-1:0]            prod;
    logic signed [EW-1:0]     mag3, res;
    logic                     sat_hi, sat_lo;
    logic signed [W_OUT-1:0]  sat_val;

    logic signed [W_OUT-1:0]  chan_reg [NS];
    logic [NS-1:0]            chan_seen;

    assign en3      = !out_valid || out_ready;
    assign en2      = !s2_v || en3;
    assign en1      = !s1_v || en2;
    assign in_ready = en1 && !rst;
    assign take     = in_valid && in_ready;
    assign xfer     = out_valid && out_ready;

    // Round to nearest on |n| as floor((2|n| + d) / 2d), sign restored later
    always_comb begin
        ext   = {{(N-W_IN){in_temp[W_IN-1]}}, in_temp};
        n_val = in_mode ? ext * KCF : (ext - F32) * KFC;
        mag   = n_val[N-1] ? -n_val : n_val;
        x_val = (mag << 1) + (in_mode ? N'(5) : N'(9));
    end

    always_comb begin
        prod = PW'(s1_x) * PW'(s1_mode ? R10 : R18);
    end

    always_comb begin
        mag3 = EW'(s2_q);
        res  = s2_neg ? -mag3 : mag3;
        if (s2_mode) res = res + OFS;
        sat_hi  = (res > MAXV);
        sat_lo  = (res < MINV);
        sat_val = res[W_OUT-1:0];
        if (sat_hi)      sat_val = MAXV[W_OUT-1:0];
        else if (sat_lo) sat_val = MINV[W_OUT-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v      <= 1'b0;
            s1_neg    <= 1'b0;
            s1_mode   <= 1'b0;
            s1_x      <= '0;
            s1_ch     <= '0;
            s2_v      <= 1'b0;
            s2_neg    <= 1'b0;
            s2_mode   <= 1'b0;
            s2_q      <= '0;
            s2_ch     <= '0;
            out_valid <= 1'b0;
            out_temp  <= '0;
            out_ch    <= '0;
            out_sat   <= 1'b0;
        end else begin
            if (en1) s1_v <= take;
            if (take) begin
                s1_neg  <= n_val[N-1];
                s1_mode <= in_mode;
                s1_x    <= x_val;
                s1_ch   <= in_ch;
            end
            if (en2) s2_v <= s1_v;
            if (en2 && s1_v) begin
                s2_neg  <= s1_neg;
                s2_mode <= s1_mode;
                s2_q    <= QW'(prod >> SH);
                s2_ch   <= s1_ch;
            end
            if (en3) out_valid <= s2_v;
            if (en3 && s2_v) begin
                out_temp <= sat_val;
                out_ch   <= s2_ch;
                out_sat  <= sat_hi || sat_lo;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NS; i++) chan_reg[i] <= '0;
            chan_seen <= '0;
            rd_temp   <= '0;
            rd_vld    <= 1'b0;
        end else begin
            if (xfer && CH_OK[out_ch]) begin
                chan_reg[out_ch]  <= out_temp;
                chan_seen[out_ch] <= 1'b1;
            end
            rd_temp <= CH_OK[rd_ch] ? chan_reg[rd_ch] : '0;
            rd_vld  <= CH_OK[rd_ch] && chan_seen[rd_ch];
        end
    end

endmodule
